fwd_hazard_unit: RTL and testbench

Parametrised forwarding and load-use hazard unit for the MIPS pipeline. Tracks in-flight register writes in an internal shift register of DEPTH post-ID stages, computes per-operand bypass selects for the instruction leaving ID, and raises a stall when a source depends on a load whose data is not yet available. It sits beside the ID/EXE pipeline register. It replaces externally supplied EXE/MEM destination tracking with self-contained, registered bookkeeping.

---
 rtl/fwd_pkg.sv | 23 ++
 rtl/fwd_src_match.sv | 34 +++
 rtl/fwd_hazard_unit.sv | 114 +++++++++++
 tb/tb_fwd_hazard_unit.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
// Shared definitions for the forwarding / load-use hazard unit:
// stage-entry bit layout, select constants and the select-width helper.
package fwd_pkg;

  localparam int SEL_RF  = 0;
  localparam int STG_EXE = 1;
  localparam int STG_MEM = 2;

  // Packed stage entry: {dst[AW-1:0], load, wb, valid} from MSB to LSB
  localparam int ENT_VLD = 0;
  localparam int ENT_WB  = 1;
  localparam int ENT_LD  = 2;
  localparam int ENT_DST = 3;

  function automatic int ent_w(input int aw);
    return aw + ENT_DST;
  endfunction

  function automatic int sel_w(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fwd_src_match.sv
// Priority match of one source operand against the in-flight stage entries.
// The youngest matching producer (lowest stage index) sets the select.
module fwd_src_match
  import fwd_pkg::*;
#(
  parameter int AW       = 5,
  parameter int DEPTH    = 2,
  parameter int LOAD_LAT = 1,
  parameter int SEL_W    = sel_w(DEPTH)
) (
  input  logic [AW-1:0]               src,
  input  logic                        used,
  input  logic [DEPTH*ent_w(AW)-1:0]  ent,
  output logic [SEL_W-1:0]            sel,
  output logic                        is_load_hit
);

  localparam int EW = ent_w(AW);

  // Walk oldest to youngest so the youngest match overwrites older ones
  always_comb begin
    sel         = SEL_W'(SEL_RF);
    is_load_hit = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (used && (src != '0) &&
          ent[(k-1)*EW + ENT_VLD] && ent[(k-1)*EW + ENT_WB] &&
          (ent[(k-1)*EW + ENT_DST +: AW] == src)) begin
        sel         = SEL_W'(k);
        is_load_hit = ent[(k-1)*EW + ENT_LD] && (k <= LOAD_LAT);
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding select and load-use stall generation with self-contained stage tracking.
// Optional FWD_HAZARD_STATS_EN adds stall / forward event counters.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int AW       = 5,
  parameter int NUM_SRC  = 2,
  parameter int DEPTH    = 2,
  parameter int LOAD_LAT = 1,
  parameter int SEL_W    = sel_w(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     id_valid,
  input  logic [NUM_SRC*AW-1:0]    id_src,
  input  logic [NUM_SRC-1:0]       id_src_used,
  input  logic [AW-1:0]            id_dst,
  input  logic                     id_wb,
  input  logic                     id_load,
  input  logic                     flush,
`ifdef FWD_HAZARD_STATS_EN
  output logic [31:0]              stat_stalls,
  output logic [31:0]              stat_fwds,
`endif
  output logic                     stall,
  output logic [NUM_SRC*SEL_W-1:0] fwd_sel
);

  localparam int EW = ent_w(AW);

  // Stage k lives at index k-1
  logic [DEPTH-1:0]         stg_vld;
  logic [DEPTH-1:0]         stg_wb;
  logic [DEPTH-1:0]         stg_ld;
  logic [DEPTH*AW-1:0]      stg_dst;
  logic [DEPTH*EW-1:0]      stg_ent;

  logic [NUM_SRC*SEL_W-1:0] sel_nxt;
  logic [NUM_SRC-1:0]       load_hit;
  logic                     issue;

  always_comb begin
    stg_ent = '0;
    for (int k = 0; k < DEPTH; k++) begin
      stg_ent[k*EW + ENT_VLD]       = stg_vld[k];
      stg_ent[k*EW + ENT_WB]        = stg_wb[k];
      stg_ent[k*EW + ENT_LD]        = stg_ld[k];
      stg_ent[k*EW + ENT_DST +: AW] = stg_dst[k*AW +: AW];
    end
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_src_match #(
      .AW       (AW),
      .DEPTH    (DEPTH),
      .LOAD_LAT (LOAD_LAT),
      .SEL_W    (SEL_W)
    ) u_match (
      .src         (id_src[i*AW +: AW]),
      .used        (id_src_used[i]),
      .ent         (stg_ent),
      .sel         (sel_nxt[i*SEL_W +: SEL_W]),
      .is_load_hit (load_hit[i])
    );
  end

  assign stall = id_valid & (|load_hit);
  assign issue = id_valid & ~stall & ~flush;

  // ID -> EXE boundary: control (valid, selects) is reset, payload is not
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_vld <= '0;
      fwd_sel <= '0;
    end else begin
      for (int k = DEPTH-1; k >= 1; k--) stg_vld[k] <= stg_vld[k-1];
      stg_vld[0] <= issue;
      fwd_sel    <= issue ? sel_nxt : '0;
    end
  end

  always_ff @(posedge clk) begin
    for (int k = DEPTH-1; k >= 1; k--) begin
      stg_wb[k]               <= stg_wb[k-1];
      stg_ld[k]               <= stg_ld[k-1];
      stg_dst[k*AW +: AW]     <= stg_dst[(k-1)*AW +: AW];
    end
    stg_wb[0]      <= id_wb;
    stg_ld[0]      <= id_load;
    stg_dst[0 +: AW] <= id_dst;
  end

`ifdef FWD_HAZARD_STATS_EN
  logic [31:0] nz_cnt;

  always_comb begin
    nz_cnt = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (sel_nxt[i*SEL_W +: SEL_W] != SEL_W'(SEL_RF)) nz_cnt = nz_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_stalls <= '0;
      stat_fwds   <= '0;
    end else begin
      if (stall && id_valid && !flush) stat_stalls <= stat_stalls + 32'd1;
      if (issue)                       stat_fwds   <= stat_fwds + nz_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: default instance plus a DEPTH=3 / LOAD_LAT=2 instance.
module tb_fwd_hazard_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [9:0] id_src;
  logic [1:0] id_src_used;
  logic [4:0] id_dst;
  logic       id_wb;
  logic       id_load;
  logic       flush;
  logic       stall_a, stall_b;
  logic [3:0] fwd_sel_a, fwd_sel_b;
`ifdef FWD_HAZARD_STATS_EN
  logic [31:0] st_stl_a, st_fwd_a, st_stl_b, st_fwd_b;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit u_dut_a (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src(id_src),
    .id_src_used(id_src_used), .id_dst(id_dst), .id_wb(id_wb),
    .id_load(id_load), .flush(flush),
`ifdef FWD_HAZARD_STATS_EN
    .stat_stalls(st_stl_a), .stat_fwds(st_fwd_a),
`endif
    .stall(stall_a), .fwd_sel(fwd_sel_a)
  );

  fwd_hazard_unit #(.DEPTH(3), .LOAD_LAT(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src(id_src),
    .id_src_used(id_src_used), .id_dst(id_dst), .id_wb(id_wb),
    .id_load(id_load), .flush(flush),
`ifdef FWD_HAZARD_STATS_EN
    .stat_stalls(st_stl_b), .stat_fwds(st_fwd_b),
`endif
    .stall(stall_b), .fwd_sel(fwd_sel_b)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Present one ID-stage instruction at the negedge, let combinational logic settle
  task automatic cyc(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                     input logic [1:0] used, input logic [4:0] dst,
                     input logic wb, input logic ld, input logic fl);
    @(negedge clk);
    id_valid    = v;
    id_src      = {s1, s0};
    id_src_used = used;
    id_dst      = dst;
    id_wb       = wb;
    id_load     = ld;
    flush       = fl;
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    id_valid = 1'b0; id_src = '0; id_src_used = '0;
    id_dst = '0; id_wb = 1'b0; id_load = 1'b0; flush = 1'b0;
    #2;
    chk("rst_stall", 32'(stall_a), 32'd0);
    chk("rst_sel",   32'(fwd_sel_a), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // ALU back-to-back, distance 2, then distance 4
    cyc(1, 5'd1, 5'd2, 2'b11, 5'd3, 1, 0, 0);           // add $3
    cyc(1, 5'd3, 5'd0, 2'b01, 5'd6, 1, 0, 0);           // reads $3
    chk("alu_prod_sel", 32'(fwd_sel_a), 32'h0);
    chk("alu_stall", 32'(stall_a), 32'd0);
    cyc(1, 5'd3, 5'd0, 2'b01, 5'd7, 1, 0, 0);           // reads $3 again
    chk("alu_d1_sel", 32'(fwd_sel_a), 32'h1);
    cyc(1, 5'd0, 5'd0, 2'b00, 5'd8, 1, 0, 0);
    chk("alu_d2_sel", 32'(fwd_sel_a), 32'h2);
    cyc(1, 5'd0, 5'd3, 2'b10, 5'd9, 1, 0, 0);           // reads $3 after 3-instr gap
    cyc(0, 5'd0, 5'd0, 2'b00, 5'd0, 0, 0, 0);
    chk("alu_gap_sel", 32'(fwd_sel_a), 32'h0);

    // Double producer of $4: youngest wins on both operands
    cyc(1, 5'd0, 5'd0, 2'b00, 5'd4, 1, 0, 0);
    cyc(1, 5'd0, 5'd0, 2'b00, 5'd4, 1, 0, 0);
    cyc(1, 5'd4, 5'd4, 2'b11, 5'd11, 1, 0, 0);
    idle();
    chk("dbl_sel", 32'(fwd_sel_a), 32'h5);

    // $0 destination is never forwarded, even from a load
    cyc(1, 5'd0, 5'd0, 2'b00, 5'd0, 1, 1, 0);
    cyc(1, 5'd0, 5'd0, 2'b11, 5'd12, 1, 0, 0);
    chk("r0_stall", 32'(stall_a), 32'd0);
    idle();
    chk("r0_sel", 32'(fwd_sel_a), 32'h0);

    // Load-use: one stall cycle, bubble, then select 2 on operand 1
    cyc(1, 5'd0, 5'd0, 2'b00, 5'd5, 1, 1, 0);           // lw $5
    cyc(1, 5'd0, 5'd5, 2'b10, 5'd10, 1, 0, 0);          // add reads $5
    chk("lu_stall1", 32'(stall_a), 32'd1);
    cyc(1, 5'd0, 5'd5, 2'b10, 5'd10, 1, 0, 0);
    chk("lu_bubble_sel", 32'(fwd_sel_a), 32'h0);
    chk("lu_stall2", 32'(stall_a), 32'd0);
    idle();
    chk("lu_fwd_sel", 32'(fwd_sel_a), 32'h8);

    // Flush while stalled: nothing captured, no later forward from it
    cyc(1, 5'd0, 5'd0, 2'b00, 5'd5, 1, 1, 0);           // lw $5
    cyc(1, 5'd0, 5'd5, 2'b10, 5'd13, 1, 0, 1);          // dependent, flushed
    chk("fl_stall", 32'(stall_a), 32'd1);
    cyc(1, 5'd13, 5'd0, 2'b01, 5'd14, 1, 0, 0);         // reads flushed dst
    chk("fl_bubble_sel", 32'(fwd_sel_a), 32'h0);
    chk("fl_no_stall", 32'(stall_a), 32'd0);
    idle();
    chk("fl_no_fwd", 32'(fwd_sel_a), 32'h0);

    // Reset asserted mid-stall
    cyc(1, 5'd0, 5'd0, 2'b00, 5'd7, 1, 0, 0);           // add $7
    cyc(1, 5'd7, 5'd0, 2'b01, 5'd8, 1, 1, 0);           // lw $8 reading $7
    cyc(1, 5'd8, 5'd0, 2'b01, 5'd9, 1, 0, 0);           // reads $8
    chk("mr_pre_sel", 32'(fwd_sel_a), 32'h1);
    chk("mr_pre_stall", 32'(stall_a), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mr_stall", 32'(stall_a), 32'd0);
    chk("mr_sel", 32'(fwd_sel_a), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mr_rel_stall", 32'(stall_a), 32'd0);
    idle();
    chk("mr_rel_sel", 32'(fwd_sel_a), 32'h0);

    // DEPTH=3, LOAD_LAT=2 instance: two stall cycles then select 3
    idle(); idle(); idle();
    cyc(1, 5'd0, 5'd0, 2'b00, 5'd5, 1, 1, 0);           // lw $5
    cyc(1, 5'd0, 5'd5, 2'b10, 5'd10, 1, 0, 0);
    chk("b_stall1", 32'(stall_b), 32'd1);
    cyc(1, 5'd0, 5'd5, 2'b10, 5'd10, 1, 0, 0);
    chk("b_stall2", 32'(stall_b), 32'd1);
    chk("b_bub1_sel", 32'(fwd_sel_b), 32'h0);
    cyc(1, 5'd0, 5'd5, 2'b10, 5'd10, 1, 0, 0);
    chk("b_stall3", 32'(stall_b), 32'd0);
    chk("b_bub2_sel", 32'(fwd_sel_b), 32'h0);
    idle();
    chk("b_fwd_sel", 32'(fwd_sel_b), 32'hC);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
